// File: rtl/exe_div_ctrl_if.sv
// Divide sequencer bundle between the EXE stage and exe_div_ctrl.
interface exe_div_ctrl_if #(
    parameter int DIV_W = 32
);
    // Handshake: EXE raises div_req with operands valid and keeps it high while
    // the instruction sits in EXE. The sequencer holds div_stall high until
    // div_done, then holds div_result until ms_allow_in lets the instruction go.
    // Dropping div_req before that point abandons the operation.
    logic             div_req;
    logic             div_signed;
    logic             div_mod;
    logic [DIV_W-1:0] div_src1;
    logic [DIV_W-1:0] div_src2;
    logic             ms_allow_in;
    logic             div_stall;
    logic             div_busy;
    logic             div_done;
    logic [DIV_W-1:0] div_result;

    modport master (
        output div_req, div_signed, div_mod, div_src1, div_src2, ms_allow_in,
        input  div_stall, div_busy, div_done, div_result
    );

    modport slave (
        input  div_req, div_signed, div_mod, div_src1, div_src2, ms_allow_in,
        output div_stall, div_busy, div_done, div_result
    );
endinterface

// File: rtl/exe_div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for the EXE stage.
// Holds EXE stalled until the quotient/remainder is ready, then keeps the
// result stable until MEM accepts the instruction.
module exe_div_ctrl #(
    parameter int DIV_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    exe_div_ctrl_if.slave  div,
    output logic [1:0]     div_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [DIV_W:0]   rem;      // 33-bit partial remainder
    logic [DIV_W-1:0] dvd;      // dividend shifting out, quotient shifting in
    logic [DIV_W-1:0] dvs;      // divisor magnitude
    logic [5:0]       cnt;
    logic             sgn_l;
    logic             mod_l;
    logic             q_neg;
    logic             r_neg;

    logic             s1;
    logic             s2;
    logic [DIV_W-1:0] mag1;
    logic [DIV_W-1:0] mag2;
    logic [DIV_W:0]   rem_sh;
    logic [DIV_W:0]   trial;
    logic [DIV_W-1:0] q_fix;
    logic [DIV_W-1:0] r_fix;

    // Operand signs and magnitudes; unsigned divides use the raw values.
    always_comb begin
        s1     = div.div_signed & div.div_src1[DIV_W-1];
        s2     = div.div_signed & div.div_src2[DIV_W-1];
        mag1   = s1 ? (~div.div_src1 + 1'b1) : div.div_src1;
        mag2   = s2 ? (~div.div_src2 + 1'b1) : div.div_src2;
        rem_sh = {rem[DIV_W-1:0], dvd[DIV_W-1]};
        trial  = rem_sh - {1'b0, dvs};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state logic; a dropped request always cancels back to IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (div.div_req) state_n = (div.div_src2 == '0) ? DONE : CALC;
            CALC: begin
                if (!div.div_req)       state_n = IDLE;
                else if (cnt == 6'd31)  state_n = DONE;
            end
            DONE: if (!div.div_req || div.ms_allow_in) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: latch operands on acceptance, one restoring step per CALC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            sgn_l <= 1'b0;
            mod_l <= 1'b0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE && div.div_req) begin
            mod_l <= div.div_mod;
            cnt   <= '0;
            if (div.div_src2 == '0) begin
                // Divide by zero: result is fixed, no sign correction.
                rem   <= {1'b0, div.div_src1};
                dvd   <= '1;
                dvs   <= '0;
                sgn_l <= 1'b0;
                q_neg <= 1'b0;
                r_neg <= 1'b0;
            end else begin
                rem   <= '0;
                dvd   <= mag1;
                dvs   <= mag2;
                sgn_l <= div.div_signed;
                q_neg <= s1 ^ s2;
                r_neg <= s1;
            end
        end else if (state == CALC && div.div_req) begin
            cnt <= cnt + 6'd1;
            if (!trial[DIV_W]) begin
                rem <= trial;
                dvd <= {dvd[DIV_W-2:0], 1'b1};
            end else begin
                rem <= rem_sh;
                dvd <= {dvd[DIV_W-2:0], 1'b0};
            end
        end
    end

    // Sign correction and result selection, visible only in DONE.
    always_comb begin
        q_fix          = (sgn_l && q_neg) ? (~dvd + 1'b1) : dvd;
        r_fix          = (sgn_l && r_neg) ? (~rem[DIV_W-1:0] + 1'b1) : rem[DIV_W-1:0];
        div.div_busy   = (state == CALC);
        div.div_done   = (state == DONE);
        div.div_result = (state == DONE) ? (mod_l ? r_fix : q_fix) : '0;
        div.div_stall  = div.div_req && (state != DONE);
        div_state      = state;
    end
endmodule

// File: tb/tb_exe_div_ctrl.sv
// Self-checking bench for exe_div_ctrl: directed corner cases plus random
// divides checked against an arithmetic reference model.
module tb_exe_div_ctrl;
    logic       clk;
    logic       reset;
    logic [1:0] dut_state;
    int         vectors;
    int         miscompares;

    exe_div_ctrl_if dif();

    exe_div_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .div       (dif),
        .div_state (dut_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, with divide-by-zero rules.
    function automatic logic [31:0] ref_div(input logic sg, input logic md,
                                            input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return md ? a : 32'hFFFF_FFFF;
        if (sg) begin
            x = $signed(a);
            y = $signed(b);
        end else begin
            x = {32'd0, a};
            y = {32'd0, b};
        end
        q  = x / y;
        r  = x % y;
        qv = q;
        rv = r;
        return md ? rv[31:0] : qv[31:0];
    endfunction

    // Waits out the stall, checks latency and result, holds in DONE, retires.
    task automatic finish_div(input logic sg, input logic md, input logic [31:0] a,
                              input logic [31:0] b, input int hold);
        int          stall_n;
        logic [31:0] exp_r;
        exp_r   = ref_div(sg, md, a, b);
        stall_n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!dif.div_stall) break;
            stall_n++;
            if (stall_n >= 2) begin
                dif.div_src1   = $urandom;
                dif.div_src2   = $urandom;
                dif.div_signed = 1'($urandom_range(0, 1));
                dif.div_mod    = 1'($urandom_range(0, 1));
            end
        end
        check("stall_cycles", 32'(stall_n), (b == 32'd0) ? 32'd1 : 32'd33);
        check("done", {31'd0, dif.div_done}, 32'd1);
        check("result", dif.div_result, exp_r);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_result", dif.div_result, exp_r);
            check("hold_stall", {31'd0, dif.div_stall}, 32'd0);
        end
        dif.ms_allow_in = 1'b1;
        @(posedge clk);
        #1;
        dif.ms_allow_in = 1'b0;
        dif.div_req     = 1'b0;
        check("retire_done", {31'd0, dif.div_done}, 32'd0);
        check("retire_busy", {31'd0, dif.div_busy}, 32'd0);
    endtask

    task automatic drive_req(input logic sg, input logic md, input logic [31:0] a,
                             input logic [31:0] b);
        dif.div_req    = 1'b1;
        dif.div_signed = sg;
        dif.div_mod    = md;
        dif.div_src1   = a;
        dif.div_src2   = b;
    endtask

    task automatic run_div(input logic sg, input logic md, input logic [31:0] a,
                           input logic [31:0] b, input int hold);
        drive_req(sg, md, a, b);
        finish_div(sg, md, a, b, hold);
    endtask

    initial begin
        logic        sg, md;
        logic [31:0] a, b;
        int          kind;
        vectors     = 0;
        miscompares = 0;

        // Reset.
        reset           = 1'b1;
        dif.div_req     = 1'b0;
        dif.div_signed  = 1'b0;
        dif.div_mod     = 1'b0;
        dif.div_src1    = '0;
        dif.div_src2    = '0;
        dif.ms_allow_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, dif.div_busy}, 32'd0);
        check("rst_done", {31'd0, dif.div_done}, 32'd0);
        check("rst_result", dif.div_result, 32'd0);
        check("rst_stall_idle", {31'd0, dif.div_stall}, 32'd0);
        dif.div_req = 1'b1;
        #1;
        check("rst_stall_req", {31'd0, dif.div_stall}, 32'd1);
        dif.div_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases.
        run_div(1'b0, 1'b0, 32'd100, 32'd7, 0);
        run_div(1'b0, 1'b1, 32'd100, 32'd7, 0);
        run_div(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
        run_div(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div(1'b0, 1'b0, 32'h1234, 32'd0, 0);
        run_div(1'b1, 1'b1, 32'h1234, 32'd0, 0);
        run_div(1'b0, 1'b0, 32'd1000, 32'd7, 5);
        run_div(1'b0, 1'b0, 32'd20, 32'd3, 0);

        // Cancel at CALC iteration 10.
        drive_req(1'b0, 1'b0, 32'd77, 32'd5);
        repeat (11) @(posedge clk);
        #1;
        check("cancel_busy_before", {31'd0, dif.div_busy}, 32'd1);
        dif.div_req = 1'b0;
        @(posedge clk);
        #1;
        check("cancel_busy", {31'd0, dif.div_busy}, 32'd0);
        check("cancel_done", {31'd0, dif.div_done}, 32'd0);
        run_div(1'b0, 1'b0, 32'd9, 32'd3, 0);

        // Asynchronous reset mid-CALC, then restart with the held request.
        drive_req(1'b1, 1'b1, 32'hFFFF_EC78, 32'd13);
        repeat (6) @(posedge clk);
        #2;
        check("arst_busy_before", {31'd0, dif.div_busy}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, dif.div_busy}, 32'd0);
        check("arst_done", {31'd0, dif.div_done}, 32'd0);
        check("arst_result", dif.div_result, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        finish_div(1'b1, 1'b1, 32'hFFFF_EC78, 32'd13, 0);

        // Random divides.
        for (int n = 0; n < 40; n++) begin
            sg   = 1'($urandom_range(0, 1));
            md   = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 7);
            a    = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case (kind)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            run_div(sg, md, a, b, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
